// File: rtl/muller_c_multi.sv
// Multi-channel generalised Muller C-element bank behind synchronised async inputs, with
// per-channel saturating transition counters and a sticky hold-timeout stall detector.
// Latency: in_data edge -> c_out edge is SYNC_STAGES+1 clocks; any_stall lags stall by one clock.
// Backpressure: none. en=0 freezes channel state; the synchronisers and cnt_clr keep acting.
//
// Ports:
//   wb_clk_i, wb_rst_i    clock, asynchronous active-high reset
//   en                    1 = channels evaluate, 0 = channel state frozen
//   in_data[NCH*NIN]      raw async inputs, channel k uses bits [k*NIN +: NIN]
//   set_mask, rst_mask    per-input participation in the rise / fall condition (shared)
//   cnt_clr               synchronous clear of counters, timers and stall flags
//   c_out, trans_cnt      C-element outputs, per-channel transition counters
//   stall, any_stall      sticky per-channel stall flags, registered OR of stall
module muller_c_multi #(
    parameter int NCH         = 4,
    parameter int NIN         = 3,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8,
    parameter int TIMEOUT     = 255
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic                   en,
    input  logic [NCH*NIN-1:0]     in_data,
    input  logic [NIN-1:0]         set_mask,
    input  logic [NIN-1:0]         rst_mask,
    input  logic                   cnt_clr,
    output logic [NCH-1:0]         c_out,
    output logic [NCH*CNT_W-1:0]   trans_cnt,
    output logic [NCH-1:0]         stall,
    output logic                   any_stall
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [TW-1:0]    TMR_MAX = TW'(TIMEOUT);
    localparam logic [TW-1:0]    TMR_ONE = 1;

    // ---------------- input synchronisers ----------------
    logic [NCH*NIN-1:0] sync_q [SYNC_STAGES];
    logic [NCH*NIN-1:0] sync_d [SYNC_STAGES];
    logic [NCH*NIN-1:0] s;

    always_comb begin
        sync_d[0] = in_data;
        for (int j = 1; j < SYNC_STAGES; j++) begin
            sync_d[j] = sync_q[j-1];
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            for (int j = 0; j < SYNC_STAGES; j++) begin
                sync_q[j] <= '0;
            end
        end else begin
            for (int j = 0; j < SYNC_STAGES; j++) begin
                sync_q[j] <= sync_d[j];
            end
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // ---------------- per-channel C-element ----------------
    for (genvar k = 0; k < NCH; k++) begin : g_ch
        logic [NIN-1:0]   s_k;
        logic [NIN-1:0]   part;
        logic             rise_ok;
        logic             fall_ok;
        logic             disagree;
        logic             flip;
        logic             c_q, c_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [TW-1:0]    tmr_q, tmr_d;
        logic             stall_q, stall_d;

        assign s_k     = s[k*NIN +: NIN];
        assign part    = set_mask | rst_mask;
        // An empty mask makes the corresponding edge impossible.
        assign rise_ok = (&(s_k | ~set_mask)) & (|set_mask);
        assign fall_ok = (&(~s_k | ~rst_mask)) & (|rst_mask);
        // Participating inputs contain both a 1 and a 0.
        assign disagree = (|(s_k & part)) & (|(~s_k & part));
        assign flip     = c_q ? fall_ok : rise_ok;

        always_comb begin
            c_d     = c_q;
            cnt_d   = cnt_q;
            tmr_d   = tmr_q;
            stall_d = stall_q;
            if (en) begin
                c_d = c_q ^ flip;
                if (flip && (cnt_q != CNT_MAX)) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
                // A flip ends the disagreement episode even if inputs still differ.
                if (disagree && !flip) begin
                    if (tmr_q != TMR_MAX) begin
                        tmr_d = tmr_q + TMR_ONE;
                    end
                end else begin
                    tmr_d = '0;
                end
                if (tmr_d == TMR_MAX) begin
                    stall_d = 1'b1;
                end
            end
            // Clear wins over a coincident transition; c_out is untouched.
            if (cnt_clr) begin
                cnt_d   = '0;
                tmr_d   = '0;
                stall_d = 1'b0;
            end
        end

        always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
            if (wb_rst_i) begin
                c_q     <= 1'b0;
                cnt_q   <= '0;
                tmr_q   <= '0;
                stall_q <= 1'b0;
            end else begin
                c_q     <= c_d;
                cnt_q   <= cnt_d;
                tmr_q   <= tmr_d;
                stall_q <= stall_d;
            end
        end

        assign c_out[k]                    = c_q;
        assign trans_cnt[k*CNT_W +: CNT_W] = cnt_q;
        assign stall[k]                    = stall_q;
    end

    // ---------------- aggregated stall ----------------
    logic any_stall_q, any_stall_d;

    always_comb begin
        any_stall_d = |stall;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            any_stall_q <= 1'b0;
        end else begin
            any_stall_q <= any_stall_d;
        end
    end

    assign any_stall = any_stall_q;

endmodule

// File: tb/tb_muller_c_multi.sv
module tb_muller_c_multi;

    localparam int NCH = 4;
    localparam int NIN = 3;
    localparam int SS  = 2;
    localparam int CW  = 4;
    localparam int TO  = 20;
    localparam int W   = NCH * NIN;
    localparam int CMAX = (1 << CW) - 1;

    logic              clk;
    logic              rst;
    logic              en;
    logic [W-1:0]      in_data;
    logic [NIN-1:0]    set_mask;
    logic [NIN-1:0]    rst_mask;
    logic              cnt_clr;
    logic [NCH-1:0]    c_out;
    logic [NCH*CW-1:0] trans_cnt;
    logic [NCH-1:0]    stall;
    logic              any_stall;

    muller_c_multi #(
        .NCH(NCH), .NIN(NIN), .SYNC_STAGES(SS), .CNT_W(CW), .TIMEOUT(TO)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .en       (en),
        .in_data  (in_data),
        .set_mask (set_mask),
        .rst_mask (rst_mask),
        .cnt_clr  (cnt_clr),
        .c_out    (c_out),
        .trans_cnt(trans_cnt),
        .stall    (stall),
        .any_stall(any_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // Inputs seen by the C-element are the raw inputs delayed by SS clocks.
    logic [W-1:0] hist[$];
    bit  m_c[NCH];
    int  m_cnt[NCH];
    int  m_run[NCH];   // length of the current disagreement run, capped at TO
    bit  m_stall[NCH];
    bit  m_any;

    task automatic model_reset();
        hist = {};
        for (int i = 0; i < SS; i++) hist.push_back('0);
        for (int k = 0; k < NCH; k++) begin
            m_c[k] = 0; m_cnt[k] = 0; m_run[k] = 0; m_stall[k] = 0;
        end
        m_any = 0;
    endtask

    // Advance the model by one clock using the inputs present at that clock.
    task automatic model_step();
        logic [W-1:0] sv;
        bit old_any;
        sv = hist.pop_front();
        hist.push_back(in_data);
        old_any = 0;
        for (int k = 0; k < NCH; k++) old_any |= m_stall[k];
        for (int k = 0; k < NCH; k++) begin
            int n_set = 0, n_set_hi = 0, n_rst = 0, n_rst_lo = 0, n_part = 0, n_part_hi = 0;
            bit rise, fall, dis, change;
            for (int i = 0; i < NIN; i++) begin
                bit b;
                b = sv[k*NIN + i];
                if (set_mask[i]) begin n_set++; if (b) n_set_hi++; end
                if (rst_mask[i]) begin n_rst++; if (!b) n_rst_lo++; end
                if (set_mask[i] || rst_mask[i]) begin n_part++; if (b) n_part_hi++; end
            end
            rise   = (n_set > 0) && (n_set_hi == n_set);
            fall   = (n_rst > 0) && (n_rst_lo == n_rst);
            change = m_c[k] ? fall : rise;
            dis    = (n_part_hi > 0) && (n_part_hi < n_part) && !change;
            if (en) begin
                if (change) begin
                    m_c[k] = !m_c[k];
                    if (m_cnt[k] < CMAX) m_cnt[k]++;
                end
                m_run[k] = dis ? ((m_run[k] < TO) ? m_run[k] + 1 : TO) : 0;
                if (m_run[k] >= TO) m_stall[k] = 1;
            end
            if (cnt_clr) begin
                m_cnt[k] = 0; m_run[k] = 0; m_stall[k] = 0;
            end
        end
        m_any = old_any;
    endtask

    task automatic compare_all();
        logic [NCH-1:0]    ec, es;
        logic [NCH*CW-1:0] ecnt;
        for (int k = 0; k < NCH; k++) begin
            ec[k] = m_c[k];
            es[k] = m_stall[k];
            ecnt[k*CW +: CW] = CW'(m_cnt[k]);
        end
        check("c_out", 32'(c_out), 32'(ec));
        check("trans_cnt", 32'(trans_cnt), 32'(ecnt));
        check("stall", 32'(stall), 32'(es));
        check("any_stall", 32'(any_stall), 32'(m_any));
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
        model_step();
        compare_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic set_ch(input int k, input logic [NIN-1:0] v);
        in_data[k*NIN +: NIN] = v;
    endtask

    // Async reset asserted mid-cycle; outputs must clear before the next edge.
    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        check("arst_c_out", 32'(c_out), 32'd0);
        check("arst_cnt", 32'(trans_cnt), 32'd0);
        check("arst_stall", 32'(stall), 32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int lat;
        rst = 1'b1; en = 1'b1; in_data = '0; set_mask = '1; rst_mask = '1; cnt_clr = 1'b0;
        model_reset();
        #12;
        compare_all();
        @(negedge clk);
        rst = 1'b0;
        run(3);

        // Symmetric rise latency on channel 0, hold on partial drop, fall.
        set_ch(0, 3'b111);
        lat = 0;
        do begin
            cycle();
            lat++;
        end while (c_out[0] == 1'b0 && lat < 10);
        check("rise_latency", 32'(lat), 32'(SS + 1));
        set_ch(0, 3'b011);
        run(6);
        check("sym_hold", 32'(c_out[0]), 32'd1);
        set_ch(0, 3'b000);
        run(5);
        check("sym_fall_cnt", 32'(trans_cnt[0 +: CW]), 32'd2);

        // Asymmetric masks.
        set_mask = 3'b011; rst_mask = 3'b110;
        set_ch(0, 3'b011); run(5);
        set_ch(0, 3'b001); run(5);
        set_ch(0, 3'b000); run(5);
        set_ch(0, 3'b100); run(5);
        check("asym_hold0", 32'(c_out[0]), 32'd0);

        // Stall detection on channel 2.
        set_mask = 3'b111; rst_mask = 3'b111;
        set_ch(2, 3'b101); run(30);
        set_ch(2, 3'b111); run(5);
        check("stall_sticky", 32'(stall[2]), 32'd1);
        cnt_clr = 1'b1; cycle(); cnt_clr = 1'b0;
        run(3);

        // Counter saturation on channel 1.
        for (int t = 0; t < 20; t++) begin
            set_ch(1, (t % 2 == 0) ? 3'b111 : 3'b000);
            run(4);
        end
        check("cnt_sat", 32'(trans_cnt[CW +: CW]), 32'(CMAX));
        // Clear coinciding with a transition.
        set_ch(1, 3'b111);
        run(2);
        cnt_clr = 1'b1; cycle(); cnt_clr = 1'b0;
        check("clr_wins", 32'(trans_cnt[CW +: CW]), 32'd0);
        check("clr_keeps_c", 32'(c_out[1]), 32'd1);
        run(2);

        // Enable freeze on channel 3.
        en = 1'b0;
        set_ch(3, 3'b111);
        run(5);
        check("en_freeze", 32'(c_out[3]), 32'd0);
        en = 1'b1;
        cycle();
        check("en_resume", 32'(c_out[3]), 32'd1);

        async_reset();

        // Empty set mask: nothing rises, inputs all agree.
        set_mask = '0; rst_mask = '1; in_data = '1;
        run(50);
        check("empty_c", 32'(c_out), 32'd0);
        check("empty_cnt", 32'(trans_cnt), 32'd0);

        // Randomised traffic.
        set_mask = '1; rst_mask = '1;
        for (int c = 0; c < 700; c++) begin
            if (c % 60 == 0) begin
                set_mask = NIN'($urandom);
                rst_mask = NIN'($urandom);
            end
            for (int k = 0; k < NCH; k++) begin
                if ($urandom_range(0, 3) == 0) begin
                    case ($urandom_range(0, 2))
                        0:       set_ch(k, '0);
                        1:       set_ch(k, '1);
                        default: set_ch(k, NIN'($urandom));
                    endcase
                end
            end
            en      = ($urandom_range(0, 15) != 0);
            cnt_clr = ($urandom_range(0, 60) == 0);
            if (c == 350) begin
                cnt_clr = 1'b0;
                async_reset();
            end
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
